button_input_ctrl: RTL and testbench

Parametrised N-channel push-button front end for the game controller path. Each raw button is synchronised, debounced and edge-detected. A priority selector keeps a registered one-hot "current selection", for example the active movement direction, which downstream game logic consumes. The block replaces ad-hoc, unsynchronised, undebounced direction latching.

---
 rtl/btn_ctrl_pkg.sv | 18 +
 rtl/btn_debounce.sv | 61 ++++++
 rtl/button_input_ctrl.sv | 96 +++++++++
 tb/tb_button_input_ctrl.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/btn_ctrl_pkg.sv
// Shared constants for the push-button front end: default sizing and
// direction channel indices. Opposite directions occupy pairs (2k, 2k+1).
package btn_ctrl_pkg;

  localparam int unsigned DEFAULT_NUM_BTNS        = 32'd4;
  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 32'd1000000;

  localparam int unsigned BTN_UP    = 32'd0;
  localparam int unsigned BTN_DOWN  = 32'd1;
  localparam int unsigned BTN_LEFT  = 32'd2;
  localparam int unsigned BTN_RIGHT = 32'd3;

  // Opposite channel of idx: the other member of its (2k, 2k+1) pair.
  function automatic int unsigned opp_idx(input int unsigned idx);
    return idx ^ 32'd1;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button channel: 2-flop synchroniser, counter debounce, debounced level
// and a one-cycle pulse on each accepted 0->1 transition.
module btn_debounce
  import btn_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic btn_level,
  output logic btn_press
);

  localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CYCLES + 32'd1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 32'd1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             press_q, press_d;

  // Any cycle where the synchronised input matches the accepted level restarts the count.
  always_comb begin
    sync1_d = btn_in;
    sync2_d = sync1_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    press_d = 1'b0;
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      level_d = sync2_q;
      cnt_d   = '0;
      press_d = sync2_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
    end
  end

  assign btn_level = level_q;
  assign btn_press = press_q;

endmodule

// File: rtl/button_input_ctrl.sv
// N-channel button front end with lowest-index-wins latched selection.
// Define REVERSE_BLOCK_EN to ignore presses of the current selection's opposite.
module button_input_ctrl
  import btn_ctrl_pkg::*;
#(
  parameter int unsigned NUM_BTNS        = DEFAULT_NUM_BTNS,
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_BTNS-1:0] btn_in,
  output logic [NUM_BTNS-1:0] btn_level,
  output logic [NUM_BTNS-1:0] btn_press,
  output logic [NUM_BTNS-1:0] sel_onehot,
  output logic                sel_valid,
  output logic                sel_update
);

  logic [NUM_BTNS-1:0] level_s;
  logic [NUM_BTNS-1:0] press_s;
  logic [NUM_BTNS-1:0] blocked_s;
  logic [NUM_BTNS-1:0] eligible_s;
  logic [NUM_BTNS-1:0] winner_s;

  logic [NUM_BTNS-1:0] sel_onehot_q, sel_onehot_d;
  logic                sel_valid_q, sel_valid_d;
  logic                sel_update_q, sel_update_d;

  if (NUM_BTNS < 32'd1) begin : g_bad_num_btns
    $error("button_input_ctrl: NUM_BTNS must be >= 1");
  end
  if (DEBOUNCE_CYCLES < 32'd1) begin : g_bad_debounce
    $error("button_input_ctrl: DEBOUNCE_CYCLES must be >= 1");
  end

  for (genvar i = 0; i < NUM_BTNS; i++) begin : g_chan
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk      (clk),
      .reset    (reset),
      .btn_in   (btn_in[i]),
      .btn_level(level_s[i]),
      .btn_press(press_s[i])
    );
  end

`ifdef REVERSE_BLOCK_EN
  if ((NUM_BTNS % 32'd2) != 32'd0) begin : g_bad_pairing
    $error("button_input_ctrl: NUM_BTNS must be even with REVERSE_BLOCK_EN");
  end
  // A channel is blocked while its pair partner is the current selection.
  for (genvar i = 0; i < NUM_BTNS; i++) begin : g_block
    assign blocked_s[i] = sel_onehot_q[opp_idx(i)];
  end
`else
  assign blocked_s = '0;
`endif

  assign eligible_s = press_s & ~blocked_s;
  // Two's-complement trick isolates the lowest set bit.
  assign winner_s   = eligible_s & (~eligible_s + NUM_BTNS'(1));

  // Latch the winner; releases and idle cycles leave the selection untouched.
  always_comb begin
    sel_onehot_d = sel_onehot_q;
    sel_valid_d  = sel_valid_q;
    sel_update_d = 1'b0;
    if (eligible_s != '0) begin
      sel_onehot_d = winner_s;
      sel_valid_d  = 1'b1;
      sel_update_d = 1'b1;
    end else begin
      sel_update_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel_onehot_q <= '0;
      sel_valid_q  <= 1'b0;
      sel_update_q <= 1'b0;
    end else begin
      sel_onehot_q <= sel_onehot_d;
      sel_valid_q  <= sel_valid_d;
      sel_update_q <= sel_update_d;
    end
  end

  assign btn_level  = level_s;
  assign btn_press  = press_s;
  assign sel_onehot = sel_onehot_q;
  assign sel_valid  = sel_valid_q;
  assign sel_update = sel_update_q;

endmodule

// File: tb/tb_button_input_ctrl.sv
// Directed bench for button_input_ctrl with NUM_BTNS=4, DEBOUNCE_CYCLES=4.
// Expectations for the blocking scenario follow REVERSE_BLOCK_EN.
module tb_button_input_ctrl;

  logic       clk;
  logic       reset;
  logic [3:0] btn_in;
  logic [3:0] btn_level;
  logic [3:0] btn_press;
  logic [3:0] sel_onehot;
  logic       sel_valid;
  logic       sel_update;

  int errors;
  int checks;

  logic [13:0] obs_s;
  assign obs_s = {btn_level, btn_press, sel_onehot, sel_valid, sel_update};

  button_input_ctrl #(
    .NUM_BTNS       (4),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .btn_in    (btn_in),
    .btn_level (btn_level),
    .btn_press (btn_press),
    .sel_onehot(sel_onehot),
    .sel_valid (sel_valid),
    .sel_update(sel_update)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset  = 1'b1;
    btn_in = 4'b0000;
    for (int e = 1; e <= 2; e++) begin
      step();
      checks++;
      if (obs_s !== 14'd0) begin
        errors++;
        $display("FAIL reset_held e%0d: got %b expected %b", e, obs_s, 14'd0);
      end
    end
    reset = 1'b0;
    for (int e = 1; e <= 3; e++) begin
      step();
      checks++;
      if (obs_s !== 14'd0) begin
        errors++;
        $display("FAIL reset_idle e%0d: got %b expected %b", e, obs_s, 14'd0);
      end
    end
  endtask

  // Asserts reset 3 time units into a cycle and checks outputs clear before the next edge.
  task automatic do_reset(input string name);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    checks++;
    if (obs_s !== 14'd0) begin
      errors++;
      $display("FAIL %s_async: got %b expected %b", name, obs_s, 14'd0);
    end
    step();
    checks++;
    if (obs_s !== 14'd0) begin
      errors++;
      $display("FAIL %s_hold: got %b expected %b", name, obs_s, 14'd0);
    end
    reset = 1'b0;
  endtask

  task automatic test_single_press();
    logic [13:0] exp;
    btn_in = 4'b0001;
    for (int e = 1; e <= 8; e++) begin
      step();
      exp = {(e >= 6) ? 4'b0001 : 4'b0000, (e == 6) ? 4'b0001 : 4'b0000,
             (e >= 7) ? 4'b0001 : 4'b0000, (e >= 7) ? 1'b1 : 1'b0, (e == 7) ? 1'b1 : 1'b0};
      checks++;
      if (obs_s !== exp) begin
        errors++;
        $display("FAIL single_press e%0d: got %b expected %b", e, obs_s, exp);
      end
    end
  endtask

  task automatic test_release();
    logic [13:0] exp;
    btn_in = 4'b0000;
    for (int e = 1; e <= 8; e++) begin
      step();
      exp = {(e < 6) ? 4'b0001 : 4'b0000, 4'b0000, 4'b0001, 1'b1, 1'b0};
      checks++;
      if (obs_s !== exp) begin
        errors++;
        $display("FAIL release e%0d: got %b expected %b", e, obs_s, exp);
      end
    end
  endtask

  task automatic test_bounce();
    logic [13:0] exp;
    int presses;
    presses = 0;
    for (int e = 1; e <= 12; e++) begin
      btn_in = (e <= 3 || e >= 5) ? 4'b0100 : 4'b0000;
      step();
      if (btn_press[2] === 1'b1) presses++;
      exp = {(e >= 10) ? 4'b0100 : 4'b0000, (e == 10) ? 4'b0100 : 4'b0000,
             (e >= 11) ? 4'b0100 : 4'b0000, (e >= 11) ? 1'b1 : 1'b0, (e == 11) ? 1'b1 : 1'b0};
      checks++;
      if (obs_s !== exp) begin
        errors++;
        $display("FAIL bounce e%0d: got %b expected %b", e, obs_s, exp);
      end
    end
    checks++;
    if (presses !== 1) begin
      errors++;
      $display("FAIL bounce_press_count: got %0d expected 1", presses);
    end
  endtask

  task automatic test_simultaneous();
    logic [13:0] exp;
    btn_in = 4'b1010;
    for (int e = 1; e <= 8; e++) begin
      step();
      exp = {(e >= 6) ? 4'b1010 : 4'b0000, (e == 6) ? 4'b1010 : 4'b0000,
             (e >= 7) ? 4'b0010 : 4'b0000, (e >= 7) ? 1'b1 : 1'b0, (e == 7) ? 1'b1 : 1'b0};
      checks++;
      if (obs_s !== exp) begin
        errors++;
        $display("FAIL simultaneous e%0d: got %b expected %b", e, obs_s, exp);
      end
    end
  endtask

  // Re-pressing the selected channel rewrites the same value but still pulses sel_update.
  task automatic test_repress();
    logic [13:0] exp;
    btn_in = 4'b0000;
    repeat (8) step();
    checks++;
    if (obs_s !== {4'b0000, 4'b0000, 4'b0010, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL repress_idle: got %b expected %b", obs_s, {4'b0000, 4'b0000, 4'b0010, 1'b1, 1'b0});
    end
    btn_in = 4'b0010;
    for (int e = 1; e <= 8; e++) begin
      step();
      exp = {(e >= 6) ? 4'b0010 : 4'b0000, (e == 6) ? 4'b0010 : 4'b0000,
             4'b0010, 1'b1, (e == 7) ? 1'b1 : 1'b0};
      checks++;
      if (obs_s !== exp) begin
        errors++;
        $display("FAIL repress e%0d: got %b expected %b", e, obs_s, exp);
      end
    end
  endtask

  task automatic test_reverse_block();
    logic [13:0] exp;
    logic [3:0]  sel_exp;
    logic        upd_exp;
    btn_in = 4'b0001;
    repeat (8) step();
    checks++;
    if (obs_s !== {4'b0001, 4'b0000, 4'b0001, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL rev_setup: got %b expected %b", obs_s, {4'b0001, 4'b0000, 4'b0001, 1'b1, 1'b0});
    end
    btn_in = 4'b0011;
    for (int e = 1; e <= 8; e++) begin
      step();
`ifdef REVERSE_BLOCK_EN
      sel_exp = 4'b0001;
      upd_exp = 1'b0;
`else
      sel_exp = (e >= 7) ? 4'b0010 : 4'b0001;
      upd_exp = (e == 7) ? 1'b1 : 1'b0;
`endif
      exp = {(e >= 6) ? 4'b0011 : 4'b0001, (e == 6) ? 4'b0010 : 4'b0000, sel_exp, 1'b1, upd_exp};
      checks++;
      if (obs_s !== exp) begin
        errors++;
        $display("FAIL rev_opposite e%0d: got %b expected %b", e, obs_s, exp);
      end
    end
    btn_in = 4'b0001;
    repeat (8) step();
`ifdef REVERSE_BLOCK_EN
    sel_exp = 4'b0001;
`else
    sel_exp = 4'b0010;
`endif
    btn_in = 4'b0111;
    for (int e = 1; e <= 8; e++) begin
      step();
`ifdef REVERSE_BLOCK_EN
      if (e >= 7) sel_exp = 4'b0100;
`endif
      exp = {(e >= 6) ? 4'b0111 : 4'b0001, (e == 6) ? 4'b0110 : 4'b0000, sel_exp, 1'b1,
             (e == 7) ? 1'b1 : 1'b0};
      checks++;
      if (obs_s !== exp) begin
        errors++;
        $display("FAIL rev_pair_press e%0d: got %b expected %b", e, obs_s, exp);
      end
    end
  endtask

  // Partial count before reset must be discarded: full latency again after release.
  task automatic test_reset_mid_debounce();
    logic [13:0] exp;
    btn_in = 4'b0100;
    repeat (4) step();
    checks++;
    if (obs_s !== 14'd0) begin
      errors++;
      $display("FAIL mid_debounce_pre: got %b expected %b", obs_s, 14'd0);
    end
    do_reset("mid_debounce");
    for (int e = 1; e <= 7; e++) begin
      step();
      exp = {(e >= 6) ? 4'b0100 : 4'b0000, (e == 6) ? 4'b0100 : 4'b0000,
             (e >= 7) ? 4'b0100 : 4'b0000, (e >= 7) ? 1'b1 : 1'b0, (e == 7) ? 1'b1 : 1'b0};
      checks++;
      if (obs_s !== exp) begin
        errors++;
        $display("FAIL mid_debounce e%0d: got %b expected %b", e, obs_s, exp);
      end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_single_press();
    test_release();
    btn_in = 4'b0000;
    do_reset("after_release");
    test_bounce();
    btn_in = 4'b0000;
    do_reset("after_bounce");
    test_simultaneous();
    test_repress();
    btn_in = 4'b0000;
    do_reset("after_repress");
    test_reverse_block();
    btn_in = 4'b0000;
    do_reset("after_reverse");
    test_reset_mid_debounce();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
